// File: rtl/native2axil_pkg.sv
// Shared definitions for the native-to-AXI4-Lite bridge: FSM encoding,
// AXI response codes and the fixed protection value.
package native2axil_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_WRESP = 3'd2,
    ST_READ  = 3'd3,
    ST_RDATA = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

  // SLVERR and DECERR both have the upper response bit set.
  function automatic logic is_err_resp(input logic [1:0] resp);
    return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
  endfunction

endpackage

// File: rtl/native2axil_adapter.sv
// Native request/ready slave port to AXI4-Lite master, one transaction in flight.
// Optional NATIVE2AXIL_ERR_EN adds native_err and a saturating err_count.
module native2axil_adapter
  import native2axil_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  native_valid,
  output logic                  native_ready,
  input  logic [ADDR_WIDTH-1:0] native_addr,
  input  logic [DATA_WIDTH-1:0] native_wdata,
  input  logic [STRB_WIDTH-1:0] native_wstrb,
  output logic [DATA_WIDTH-1:0] native_rdata,
  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]            m_axil_awprot,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  output logic [DATA_WIDTH-1:0] m_axil_wdata,
  output logic [STRB_WIDTH-1:0] m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready,
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready
`ifdef NATIVE2AXIL_ERR_EN
  ,
  output logic                  native_err,
  output logic [7:0]            err_count
`endif
);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  arvalid_q, arvalid_d;
  logic                  bready_q, bready_d;
  logic                  rready_q, rready_d;
  logic                  native_ready_q, native_ready_d;
  logic                  aw_done, w_done;

  always_comb begin
    // NOTE: every signal written here is defaulted first, so no path can infer a latch.
    state_d        = state_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    wstrb_d        = wstrb_q;
    rdata_d        = rdata_q;
    awvalid_d      = awvalid_q;
    wvalid_d       = wvalid_q;
    arvalid_d      = arvalid_q;
    bready_d       = bready_q;
    rready_d       = rready_q;
    native_ready_d = 1'b0;
    aw_done        = 1'b0;
    w_done         = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (native_valid) begin
          addr_d  = native_addr;
          wdata_d = native_wdata;
          wstrb_d = native_wstrb;
          if (|native_wstrb) begin
            state_d   = ST_WRITE;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = ST_READ;
            arvalid_d = 1'b1;
          end
        end
      end
      ST_WRITE: begin
        // AW and W complete independently; a dropped valid marks its channel done.
        if (m_axil_awready) awvalid_d = 1'b0;
        if (m_axil_wready)  wvalid_d  = 1'b0;
        aw_done = !awvalid_d;
        w_done  = !wvalid_d;
        if (aw_done && w_done) begin
          state_d  = ST_WRESP;
          bready_d = 1'b1;
        end
      end
      ST_WRESP: begin
        if (m_axil_bvalid) begin
          bready_d       = 1'b0;
          state_d        = ST_DONE;
          native_ready_d = 1'b1;
        end
      end
      ST_READ: begin
        if (m_axil_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_RDATA;
        end
      end
      ST_RDATA: begin
        if (m_axil_rvalid) begin
          rdata_d        = m_axil_rdata;
          rready_d       = 1'b0;
          state_d        = ST_DONE;
          native_ready_d = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q        <= ST_IDLE;
      addr_q         <= '0;
      wdata_q        <= '0;
      wstrb_q        <= '0;
      rdata_q        <= '0;
      awvalid_q      <= 1'b0;
      wvalid_q       <= 1'b0;
      arvalid_q      <= 1'b0;
      bready_q       <= 1'b0;
      rready_q       <= 1'b0;
      native_ready_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q        <= state_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      wstrb_q        <= wstrb_d;
      rdata_q        <= rdata_d;
      awvalid_q      <= awvalid_d;
      wvalid_q       <= wvalid_d;
      arvalid_q      <= arvalid_d;
      bready_q       <= bready_d;
      rready_q       <= rready_d;
      native_ready_q <= native_ready_d;
    end
  end

`ifdef NATIVE2AXIL_ERR_EN
  logic       err_q, err_d;
  logic [7:0] err_count_q, err_count_d;

  always_comb begin
    err_d       = 1'b0;
    err_count_d = err_count_q;
    if (state_q == ST_WRESP && m_axil_bvalid && is_err_resp(m_axil_bresp)) err_d = 1'b1;
    if (state_q == ST_RDATA && m_axil_rvalid && is_err_resp(m_axil_rresp)) err_d = 1'b1;
    if (err_d && err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_q       <= 1'b0;
      err_count_q <= 8'd0;
    end else begin
      err_q       <= err_d;
      err_count_q <= err_count_d;
    end
  end

  assign native_err = err_q;
  assign err_count  = err_count_q;
`else
  // Response codes are deliberately ignored in this build.
  logic unused_resp;
  assign unused_resp = ^{m_axil_bresp, m_axil_rresp};
`endif

  assign native_ready   = native_ready_q;
  assign native_rdata   = rdata_q;
  assign m_axil_awaddr  = addr_q;
  assign m_axil_awprot  = AXI_PROT_DEFAULT;
  assign m_axil_awvalid = awvalid_q;
  assign m_axil_wdata   = wdata_q;
  assign m_axil_wstrb   = wstrb_q;
  assign m_axil_wvalid  = wvalid_q;
  assign m_axil_bready  = bready_q;
  assign m_axil_araddr  = addr_q;
  assign m_axil_arprot  = AXI_PROT_DEFAULT;
  assign m_axil_arvalid = arvalid_q;
  assign m_axil_rready  = rready_q;

endmodule

// File: tb/tb_native2axil_adapter.sv
// Bench for native2axil_adapter: delay-configurable AXI4-Lite slave plus a
// transaction-level model (expected handshakes, latency, read data, errors).
module tb_native2axil_adapter;

  logic        clk  = 1'b0;
  logic        rstn = 1'b0;
  logic        native_valid = 1'b0;
  logic        native_ready;
  logic [31:0] native_addr  = '0;
  logic [31:0] native_wdata = '0;
  logic [3:0]  native_wstrb = '0;
  logic [31:0] native_rdata;
  logic [31:0] m_axil_awaddr;
  logic [2:0]  m_axil_awprot;
  logic        m_axil_awvalid;
  logic        m_axil_awready = 1'b0;
  logic [31:0] m_axil_wdata;
  logic [3:0]  m_axil_wstrb;
  logic        m_axil_wvalid;
  logic        m_axil_wready = 1'b0;
  logic [1:0]  m_axil_bresp  = 2'b00;
  logic        m_axil_bvalid = 1'b0;
  logic        m_axil_bready;
  logic [31:0] m_axil_araddr;
  logic [2:0]  m_axil_arprot;
  logic        m_axil_arvalid;
  logic        m_axil_arready = 1'b0;
  logic [31:0] m_axil_rdata  = '0;
  logic [1:0]  m_axil_rresp  = 2'b00;
  logic        m_axil_rvalid = 1'b0;
  logic        m_axil_rready;
`ifdef NATIVE2AXIL_ERR_EN
  logic        native_err;
  logic [7:0]  err_count;
`endif

  native2axil_adapter dut (
    .clk(clk), .rstn(rstn),
    .native_valid(native_valid), .native_ready(native_ready),
    .native_addr(native_addr), .native_wdata(native_wdata),
    .native_wstrb(native_wstrb), .native_rdata(native_rdata),
    .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
    .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
    .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
    .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
    .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid),
    .m_axil_bready(m_axil_bready),
    .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot),
    .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
    .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp),
    .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready)
`ifdef NATIVE2AXIL_ERR_EN
    ,
    .native_err(native_err), .err_count(err_count)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Slave configuration: cycles of valid (or ready) before the slave answers.
  int          aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
  logic [1:0]  b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
  logic [31:0] r_data_cfg = '0;

  // Slave monitor results.
  int          aw_hs_n = 0, w_hs_n = 0, ar_hs_n = 0, ar_cycles = 0;
  int          bready_early = 0, prot_bad = 0;
  logic [31:0] aw_addr_seen = '0, w_data_seen = '0, ar_addr_seen = '0;
  logic [3:0]  w_strb_seen = '0;

  // Reference model state.
  logic [31:0] model_rdata   = '0;
  int          model_err_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Slave: drives readies/responses on negedge and records the handshakes that
  // will complete on the following posedge.
  initial begin
    int  aw_age = 0, w_age = 0, ar_age = 0, b_age = 0, r_age = 0;
    bit  aw_since = 0, w_since = 0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        m_axil_awready = 0; m_axil_wready = 0; m_axil_arready = 0;
        m_axil_bvalid = 0; m_axil_rvalid = 0;
        aw_age = 0; w_age = 0; ar_age = 0; b_age = 0; r_age = 0;
        aw_since = 0; w_since = 0;
      end else begin
        if (m_axil_bready && !(aw_since && w_since)) bready_early++;
        if (m_axil_awvalid) begin m_axil_awready = (aw_age >= aw_dly); aw_age++; end
        else begin m_axil_awready = 0; aw_age = 0; end
        if (m_axil_wvalid) begin m_axil_wready = (w_age >= w_dly); w_age++; end
        else begin m_axil_wready = 0; w_age = 0; end
        if (m_axil_arvalid) begin m_axil_arready = (ar_age >= ar_dly); ar_age++; ar_cycles++; end
        else begin m_axil_arready = 0; ar_age = 0; end
        if (m_axil_bready) begin m_axil_bvalid = (b_age >= b_dly); b_age++; m_axil_bresp = b_resp_cfg; end
        else begin m_axil_bvalid = 0; b_age = 0; end
        if (m_axil_rready) begin
          m_axil_rvalid = (r_age >= r_dly); r_age++;
          m_axil_rdata = r_data_cfg; m_axil_rresp = r_resp_cfg;
        end else begin m_axil_rvalid = 0; r_age = 0; end
        if (m_axil_awvalid && m_axil_awready) begin
          aw_hs_n++; aw_addr_seen = m_axil_awaddr; aw_since = 1;
          if (m_axil_awprot != 3'b000) prot_bad++;
        end
        if (m_axil_wvalid && m_axil_wready) begin
          w_hs_n++; w_data_seen = m_axil_wdata; w_strb_seen = m_axil_wstrb; w_since = 1;
        end
        if (m_axil_arvalid && m_axil_arready) begin
          ar_hs_n++; ar_addr_seen = m_axil_araddr;
          if (m_axil_arprot != 3'b000) prot_bad++;
        end
        if (m_axil_bvalid && m_axil_bready) begin aw_since = 0; w_since = 0; end
      end
    end
  end

  // One native transaction. held: issued during the previous DONE cycle.
  // keep: leave native_valid high on return for a back-to-back follow-up.
  task automatic run_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         input bit held, input bit keep, input string tag);
    int  n = 0, exp_lat;
    bit  got = 0, scrambled = 0, is_wr;
    int  aw0 = aw_hs_n, w0 = w_hs_n, ar0 = ar_hs_n, early0 = bready_early, prot0 = prot_bad;
    logic [1:0] resp;
    is_wr   = (s != 4'h0);
    exp_lat = is_wr ? 3 + ((aw_dly > w_dly) ? aw_dly : w_dly) + b_dly : 3 + ar_dly + r_dly;
    if (held) exp_lat++;
    resp = is_wr ? b_resp_cfg : r_resp_cfg;
    native_valid = 1; native_addr = a; native_wdata = d; native_wstrb = s;
    while (!got && n < 200) begin
      @(posedge clk); #1; n++;
      if (native_ready) got = 1;
      else if (!scrambled && (m_axil_awvalid || m_axil_arvalid)) begin
        native_addr = $urandom; native_wdata = $urandom; native_wstrb = 4'($urandom_range(0, 15));
        scrambled = 1;
      end
    end
    if (!is_wr) model_rdata = r_data_cfg;
    if (resp[1] && model_err_cnt < 255) model_err_cnt++;
    check({tag, "/completed"}, 64'(got), 64'd1);
    check({tag, "/latency"}, 64'(n), 64'(exp_lat));
    check({tag, "/rdata"}, 64'(native_rdata), 64'(model_rdata));
    check({tag, "/aw_count"}, 64'(aw_hs_n - aw0), 64'(is_wr));
    check({tag, "/w_count"}, 64'(w_hs_n - w0), 64'(is_wr));
    check({tag, "/ar_count"}, 64'(ar_hs_n - ar0), 64'(!is_wr));
    check({tag, "/bready_early"}, 64'(bready_early - early0), 64'd0);
    check({tag, "/prot"}, 64'(prot_bad - prot0), 64'd0);
    if (is_wr) begin
      check({tag, "/awaddr"}, 64'(aw_addr_seen), 64'(a));
      check({tag, "/wdata"}, 64'(w_data_seen), 64'(d));
      check({tag, "/wstrb"}, 64'(w_strb_seen), 64'(s));
    end else begin
      check({tag, "/araddr"}, 64'(ar_addr_seen), 64'(a));
    end
`ifdef NATIVE2AXIL_ERR_EN
    check({tag, "/native_err"}, 64'(native_err), 64'(resp[1]));
    check({tag, "/err_count"}, 64'(err_count), 64'(model_err_cnt));
`endif
    if (!keep) begin
      native_valid = 0;
      @(posedge clk); #1;
      check({tag, "/ready_pulse"}, 64'(native_ready), 64'd0);
    end
  endtask

  initial begin
    int  ar0, n;
    bit  seen, prev_keep;
    repeat (2) @(posedge clk);
    #1;
    check("reset/ready", 64'(native_ready), 64'd0);
    check("reset/valids", 64'({m_axil_awvalid, m_axil_wvalid, m_axil_arvalid,
                                m_axil_bready, m_axil_rready}), 64'd0);
    check("reset/regs", {m_axil_awaddr, m_axil_wdata}, 64'd0);
    check("reset/strb_araddr", 64'({m_axil_wstrb, m_axil_araddr}), 64'd0);
    check("reset/rdata", 64'(native_rdata), 64'd0);
`ifdef NATIVE2AXIL_ERR_EN
    check("reset/err", 64'({native_err, err_count}), 64'd0);
`endif
    @(negedge clk); rstn = 1;

    // Minimum-latency write.
    run_txn(32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, "wr_min");

    // Read with arready delayed 3 cycles: arvalid visible for 4 cycles.
    ar_dly = 3; r_data_cfg = 32'h1234_5678; ar0 = ar_cycles;
    run_txn(32'h0000_0020, 32'h0, 4'h0, 0, 0, "rd_ardly");
    check("rd_ardly/ar_cycles", 64'(ar_cycles - ar0), 64'd4);
    ar_dly = 0;

    // W before AW, then AW before W.
    aw_dly = 2; w_dly = 0;
    run_txn(32'h0000_0104, 32'hA5A5_0001, 4'h3, 0, 0, "wr_w_first");
    aw_dly = 0; w_dly = 2;
    run_txn(32'h0000_0108, 32'hA5A5_0002, 4'hC, 0, 0, "wr_aw_first");
    w_dly = 0;

    // Back-to-back write then read, native_valid held across DONE.
    r_data_cfg = 32'hCAFE_F00D;
    run_txn(32'h0000_0200, 32'h1111_2222, 4'h1, 0, 1, "b2b_wr");
    run_txn(32'h0000_0204, 32'h0, 4'h0, 1, 0, "b2b_rd");

    // Reset while waiting for the write response.
    b_dly = 20;
    native_valid = 1; native_addr = 32'h300; native_wdata = 32'h77; native_wstrb = 4'hF;
    seen = 0; n = 0;
    while (!seen && n < 50) begin
      @(posedge clk); #1; n++;
      if (m_axil_bready) seen = 1;
    end
    check("abort/reached_wresp", 64'(seen), 64'd1);
    #2 rstn = 0;
    #1;
    check("abort/outputs_low", 64'({m_axil_awvalid, m_axil_wvalid, m_axil_arvalid,
                                    m_axil_bready, m_axil_rready, native_ready}), 64'd0);
    native_valid = 0; b_dly = 0;
    model_rdata = '0; model_err_cnt = 0;
    repeat (2) @(negedge clk);
    rstn = 1;
    seen = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (native_ready) seen = 1;
    end
    check("abort/no_ready", 64'(seen), 64'd0);
    check("abort/rdata_cleared", 64'(native_rdata), 64'd0);
    r_data_cfg = 32'h0BAD_C0DE;
    run_txn(32'h0000_0040, 32'h0, 4'h0, 0, 0, "post_reset_rd");

    // Error response then an OKAY read.
    b_resp_cfg = 2'b10;
    run_txn(32'h0000_0050, 32'h5555_AAAA, 4'hF, 0, 0, "wr_slverr");
    b_resp_cfg = 2'b00; r_resp_cfg = 2'b00; r_data_cfg = 32'h0000_00EE;
    run_txn(32'h0000_0054, 32'h0, 4'h0, 0, 0, "rd_okay");

    // Randomized traffic against the model.
    prev_keep = 0;
    for (int i = 0; i < 24; i++) begin
      logic [31:0] a, d;
      logic [3:0]  s;
      bit          keep;
      aw_dly = int'($urandom_range(0, 3)); w_dly = int'($urandom_range(0, 3));
      ar_dly = int'($urandom_range(0, 3)); b_dly = int'($urandom_range(0, 3));
      r_dly  = int'($urandom_range(0, 3));
      b_resp_cfg = 2'($urandom_range(0, 3)); r_resp_cfg = 2'($urandom_range(0, 3));
      r_data_cfg = $urandom;
      a = $urandom & 32'hFFFF_FFFC; d = $urandom;
      s = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
      keep = (i != 23) && ($urandom_range(0, 3) == 0);
      run_txn(a, d, s, prev_keep, keep, $sformatf("rand%0d", i));
      prev_keep = keep;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
